// File: rtl/div_pkg.sv
// Shared types, widths and the round-robin pick helper for the shared divider arbiter.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned QUOT_W     = 8;
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit among valid[0..n-1], searching upward from ptr with wrap-around.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int unsigned        n);
        pick_t            res;
        int unsigned      j;
        logic [IDX_W-1:0] jj;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = 32'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                jj = j[IDX_W-1:0];
                if (!res.found && valid[jj]) begin
                    res.found = 1'b1;
                    res.idx   = jj;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_div_core.sv
// Iterative 16/8 restoring divider: one quotient bit per clock, operands latched on start.
module seq_div_core
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    logic [DIVISOR_W:0]   pr_q;
    logic [DIVISOR_W:0]   pr_shift;
    logic [DIVISOR_W:0]   pr_nxt;
    logic [QUOT_W-1:0]    q_q;
    logic [QUOT_W-1:0]    q_nxt;
    logic [2:0]           cnt_q;
    logic [QUOT_W-1:0]    lo_q;
    logic [DIVISOR_W-1:0] dvs_q;
    logic                 run_q;
    logic                 ge;

    // pr_q[8] is the bit shifted out; if set, the shifted value already exceeds any divisor.
    always_comb begin
        pr_shift = {pr_q[DIVISOR_W-1:0], lo_q[cnt_q]};
        ge       = pr_q[DIVISOR_W] || (pr_shift >= {1'b0, dvs_q});
        pr_nxt   = ge ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
        q_nxt    = q_q;
        q_nxt[cnt_q] = ge;
    end

    // done flags the final step; results are presented as that step's outcome.
    assign done      = run_q && (cnt_q == '0);
    assign quotient  = q_nxt;
    assign remainder = pr_nxt[DIVISOR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            lo_q  <= '0;
            dvs_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            pr_q  <= {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
            lo_q  <= dividend[QUOT_W-1:0];
            dvs_q <= divisor;
            q_q   <= '0;
            cnt_q <= 3'd7;
            run_q <= 1'b1;
        end else if (run_q) begin
            pr_q <= pr_nxt;
            q_q  <= q_nxt;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative 16/8 divider among NUM_REQ requesters,
// with operand pre-check and an id-tagged response channel.
module div_share_arbiter
    import div_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DIVIDEND_W-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_W-1:0]    req_divisor,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [QUOT_W-1:0]               rsp_quotient,
    output logic [DIVISOR_W-1:0]            rsp_remainder,
    output logic                            rsp_err,
    output logic                            busy
);

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      ptr_nxt;
    logic [ID_W-1:0]       id_q;
    logic [MAX_REQ-1:0]    valid_ext;
    pick_t                 pick;
    logic                  accept;
    logic                  op_illegal;
    logic                  start_core;
    logic [DIVIDEND_W-1:0] sel_dividend;
    logic [DIVISOR_W-1:0]  sel_divisor;
    logic                  core_done;
    logic [QUOT_W-1:0]     core_quotient;
    logic [DIVISOR_W-1:0]  core_remainder;

    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = req_valid;
        pick = rr_pick(valid_ext, rr_ptr_q, NUM_REQ);
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(pick.idx) == i) begin
                sel_dividend = req_dividend[DIVIDEND_W*i +: DIVIDEND_W];
                sel_divisor  = req_divisor[DIVISOR_W*i +: DIVISOR_W];
            end
        end
    end

    // Gated by rst_n so no grant is offered while reset is held.
    assign accept     = rst_n && (state_q == IDLE) && pick.found;
    assign op_illegal = (sel_divisor == '0) ||
                        (sel_dividend[DIVIDEND_W-1:DIVISOR_W] >= sel_divisor);
    assign ptr_nxt    = ((32'(pick.idx) + 32'd1) >= NUM_REQ) ? '0 : (pick.idx + 3'd1);

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept && (32'(pick.idx) == i)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_core = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_illegal) begin
                        state_d = RESP;
                    end else begin
                        state_d    = CALC;
                        start_core = 1'b1;
                    end
                end
            end
            CALC: begin
                if (core_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    // Response registers change only when entering RESP, so they hold through back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            id_q          <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_q <= ptr_nxt;
                id_q     <= pick.idx[ID_W-1:0];
            end
            if (accept && op_illegal) begin
                rsp_id        <= pick.idx[ID_W-1:0];
                rsp_quotient  <= '0;
                rsp_remainder <= '0;
                rsp_err       <= 1'b1;
            end else if ((state_q == CALC) && core_done) begin
                rsp_id        <= id_q;
                rsp_quotient  <= core_quotient;
                rsp_remainder <= core_remainder;
                rsp_err       <= 1'b0;
            end
        end
    end

    seq_div_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_core),
        .dividend  (sel_dividend),
        .divisor   (sel_divisor),
        .done      (core_done),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a transaction-level reference model.
module tb_div_share_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_dividend;
    logic [N*8-1:0]  req_divisor;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_quotient;
    logic [7:0]      rsp_remainder;
    logic            rsp_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Model state: next rr start, whether an operation is in flight,
    // cycles left before the response shows, and the expected response.
    int m_ptr    = 0;
    bit m_active = 1'b0;
    int m_left   = 0;
    int m_id     = 0;
    int m_q      = 0;
    int m_r      = 0;
    bit m_err    = 1'b0;

    always #5 clk = ~clk;

    div_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : model
        int           w;
        int           dvd;
        int           dvs;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            m_ptr    = 0;
            m_active = 1'b0;
            check("m_rst_valid", rsp_valid, 1'b0);
            check("m_rst_busy", busy, 1'b0);
            check("m_rst_ready", req_ready, '0);
            check("m_rst_id", rsp_id, '0);
            check("m_rst_q", rsp_quotient, '0);
            check("m_rst_r", rsp_remainder, '0);
            check("m_rst_err", rsp_err, 1'b0);
        end else if (!m_active) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            check("m_idle_ready", req_ready, exp_ready);
            check("m_idle_busy", busy, 1'b0);
            check("m_idle_valid", rsp_valid, 1'b0);
            if (w >= 0) begin
                dvd      = int'(req_dividend[16*w +: 16]);
                dvs      = int'(req_divisor[8*w +: 8]);
                m_ptr    = (w + 1) % N;
                m_active = 1'b1;
                m_id     = w;
                if (dvs == 0 || dvd / dvs > 255) begin
                    m_err  = 1'b1;
                    m_q    = 0;
                    m_r    = 0;
                    m_left = 0;
                end else begin
                    m_err  = 1'b0;
                    m_q    = dvd / dvs;
                    m_r    = dvd % dvs;
                    m_left = 8;
                end
            end
        end else if (m_left > 0) begin
            check("m_calc_busy", busy, 1'b1);
            check("m_calc_valid", rsp_valid, 1'b0);
            check("m_calc_ready", req_ready, '0);
            m_left--;
        end else begin
            check("m_rsp_valid", rsp_valid, 1'b1);
            check("m_rsp_busy", busy, 1'b1);
            check("m_rsp_ready", req_ready, '0);
            check("m_rsp_id", rsp_id, m_id);
            check("m_rsp_q", rsp_quotient, m_q);
            check("m_rsp_r", rsp_remainder, m_r);
            check("m_rsp_err", rsp_err, m_err);
            if (rsp_ready) m_active = 1'b0;
        end
    end

    task automatic set_op(input int id, input logic [15:0] dvd, input logic [7:0] dvs);
        req_dividend[16*id +: 16] = dvd;
        req_divisor[8*id +: 8]    = dvs;
    endtask

    // Returns just after the accepting edge.
    task automatic wait_accept(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept", req_ready[id], 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_single(input int id, input logic [15:0] dvd, input logic [7:0] dvs,
                             input int exp_lat, input int exp_q, input int exp_r,
                             input bit exp_err, input bit scramble);
        int lat;
        set_op(id, dvd, dvs);
        req_valid[id] = 1'b1;
        wait_accept(id);
        req_valid[id] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            if (scramble) set_op(id, 16'($urandom()), 8'($urandom()));
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("lit_id", rsp_id, id);
        check("lit_q", rsp_quotient, exp_q);
        check("lit_r", rsp_remainder, exp_r);
        check("lit_err", rsp_err, exp_err);
    endtask

    initial begin
        int lat;
        int n_acc;
        int guard;
        int acc_id[5];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        acc_id    = '{-1, -1, -1, -1, -1};

        rst_n        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_single(1, 16'h03E8, 8'd7, 9, 142, 6, 1'b0, 1'b0);
        do_single(0, 16'h1234, 8'd0, 1, 0, 0, 1'b1, 1'b0);
        do_single(0, 16'h0800, 8'd8, 1, 0, 0, 1'b1, 1'b0);
        do_single(0, 16'h07FF, 8'd8, 9, 255, 7, 1'b0, 1'b0);
        do_single(3, 16'h0FA1, 8'h3B, 9, 67, 48, 1'b0, 1'b1);
        wait_idle();

        for (int i = 0; i < N; i++) set_op(i, 16'd100, 8'd10);
        req_valid = '1;
        n_acc = 0;
        guard = 0;
        while (n_acc < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) acc_id[n_acc] = i;
                end
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        check("accept_count", n_acc, 5);
        for (int k = 0; k < 5; k++) check("rr_order", acc_id[k], exp_order[k]);
        wait_idle();

        set_op(1, 16'd100, 8'd10);
        set_op(2, 16'd80, 8'd5);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        check("hold_latency", lat, 9);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_id", rsp_id, 1);
            check("hold_q", rsp_quotient, 10);
            check("hold_r", rsp_remainder, 0);
            check("hold_ready", req_ready, '0);
            check("hold_busy", busy, 1'b1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", rsp_valid, 1'b0);
        check("release_busy", busy, 1'b0);
        check("next_ready", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("next_busy", busy, 1'b1);
        wait_rsp(lat);
        check("next_latency", lat, 9);
        check("next_id", rsp_id, 2);
        check("next_q", rsp_quotient, 16);
        wait_idle();

        set_op(0, 16'd100, 8'd10);
        req_valid = 4'b0001;
        wait_accept(0);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", rsp_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_id", rsp_id, 0);
        check("abort_q", rsp_quotient, 0);
        check("abort_r", rsp_remainder, 0);
        check("abort_err", rsp_err, 1'b0);
        set_op(2, 16'h00FF, 8'h10);
        req_valid = 4'b0100;
        #1;
        check("abort_ready", req_ready, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_single(2, 16'h00FF, 8'h10, 9, 15, 15, 1'b0, 1'b0);

        rst_n = 1'b0;
        set_op(1, 16'd100, 8'd10);
        set_op(3, 16'd100, 8'd10);
        req_valid = 4'b1010;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ptr_reset_pick", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
